cfg_chain_ctrl: RTL and testbench



---
 rtl/cfg_chain_ctrl.sv | 110 +++++++++++
 tb/tb_cfg_chain_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_chain_ctrl.sv
// Serial configuration controller: shifts a parallel word LSB-first into a
// master-slave flop chain, pulses the shadow update and returns the old contents.
module cfg_chain_ctrl #(
    parameter int WIDTH = 16,
    parameter int HALF  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             sclk,
    output logic             sdo,
    input  logic             sdi,
    output logic             upd,
    output logic             busy
);

    // Handshake: a word is taken on any cycle where wr_valid && wr_ready;
    // wr_valid while busy is ignored and nothing is queued.
    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, UPDATE} state_t;

    localparam int HCW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int CW  = $clog2(WIDTH + 1);
    localparam logic [HCW-1:0] H_LAST = HCW'(HALF - 1);
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    state_t           state, state_n;
    logic [HCW-1:0]   hcnt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] capture;
    logic             phase_end;

    assign phase_end = (hcnt == H_LAST);
    assign wr_ready  = (state == IDLE) && !rst;
    assign busy      = !wr_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (wr_valid)  state_n = SHIFT_LO;
            SHIFT_LO: if (phase_end) state_n = SHIFT_HI;
            SHIFT_HI: if (phase_end) state_n = (cnt == C_LAST) ? UPDATE : SHIFT_LO;
            UPDATE:   if (phase_end) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Pin flops are loaded on the transition into the state that owns them,
    // so sclk/sdo/upd line up with the state register and never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt     <= '0;
            cnt      <= '0;
            shreg    <= '0;
            capture  <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            sclk     <= 1'b0;
            sdo      <= 1'b0;
            upd      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (state_n != state || state == IDLE) hcnt <= '0;
            else                                   hcnt <= hcnt + 1'b1;

            case (state)
                IDLE: begin
                    if (wr_valid) begin
                        shreg <= wr_data;
                        cnt   <= '0;
                        sdo   <= wr_data[0];
                    end
                end
                SHIFT_LO: begin
                    if (phase_end) sclk <= 1'b1;
                end
                SHIFT_HI: begin
                    // The chain's slave stage only moves on the falling edge,
                    // so the tail still shows the old bit here.
                    if (hcnt == '0) capture <= {sdi, capture[WIDTH-1:1]};
                    if (phase_end) begin
                        shreg <= shreg >> 1;
                        cnt   <= cnt + 1'b1;
                        sclk  <= 1'b0;
                        if (cnt == C_LAST) upd <= 1'b1;
                        else               sdo <= shreg[1];
                    end
                end
                UPDATE: begin
                    if (phase_end) begin
                        upd      <= 1'b0;
                        rd_valid <= 1'b1;
                        rd_data  <= capture;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_chain_ctrl.sv
// Bench for cfg_chain_ctrl: timing and readback of the default build against a
// cycle-offset reference model, plus a directed run of a WIDTH=8/HALF=1 build.
module tb_cfg_chain_ctrl;

    localparam int WA  = 16;
    localparam int HA  = 2;
    localparam int SHA = 2 * HA * WA;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] a_wr_data, a_rd_data;
    logic        a_wr_valid, a_wr_ready, a_rd_valid, a_sclk, a_sdo, a_sdi, a_upd, a_busy;
    logic [7:0]  b_wr_data, b_rd_data;
    logic        b_wr_valid, b_wr_ready, b_rd_valid, b_sclk, b_sdo, b_sdi, b_upd, b_busy;

    cfg_chain_ctrl #(.WIDTH(WA), .HALF(HA)) dut_a (
        .clk(clk), .rst(rst), .wr_data(a_wr_data), .wr_valid(a_wr_valid),
        .wr_ready(a_wr_ready), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .sclk(a_sclk), .sdo(a_sdo), .sdi(a_sdi), .upd(a_upd), .busy(a_busy)
    );

    cfg_chain_ctrl #(.WIDTH(8), .HALF(1)) dut_b (
        .clk(clk), .rst(rst), .wr_data(b_wr_data), .wr_valid(b_wr_valid),
        .wr_ready(b_wr_ready), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .sclk(b_sclk), .sdo(b_sdo), .sdi(b_sdi), .upd(b_upd), .busy(b_busy)
    );

    // Master-slave chain models: master samples on sclk rise, slave follows on fall.
    logic [15:0] a_master = 16'h1234, a_slave = 16'h1234, a_shadow = 16'h0000;
    logic [7:0]  b_master = 8'h3C,    b_slave = 8'h3C,    b_shadow = 8'h00;
    int          a_rises = 0, b_rises = 0;

    assign a_sdi = a_slave[0];
    assign b_sdi = b_slave[0];
    always @(posedge a_sclk) begin a_master <= {a_sdo, a_slave[15:1]}; a_rises <= a_rises + 1; end
    always @(negedge a_sclk) a_slave <= a_master;
    always @(posedge clk) if (a_upd) a_shadow <= a_slave;
    always @(posedge b_sclk) begin b_master <= {b_sdo, b_slave[7:1]}; b_rises <= b_rises + 1; end
    always @(negedge b_sclk) b_slave <= b_master;
    always @(posedge clk) if (b_upd) b_shadow <= b_slave;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model and scoreboard for dut_a.
    logic [15:0] a_exp_q[$];
    logic [15:0] a_word_q[$];
    int          a_rise_q[$];
    bit          a_act = 1'b0;
    int          a_t0;
    logic [15:0] a_word;
    logic        a_last_sdo = 1'b0;
    int          mk, mbit;
    logic        e_sclk, e_sdo, e_upd, e_rdv;

    always @(negedge clk) begin
        if (rst) begin
            if (a_wr_valid) check("ready_during_rst", 32'(a_wr_ready), 32'(0));
            a_act = 1'b0;
            a_last_sdo = 1'b0;
            a_exp_q.delete();
            a_word_q.delete();
            a_rise_q.delete();
        end else begin
            e_sclk = 1'b0; e_upd = 1'b0; e_rdv = 1'b0; e_sdo = a_last_sdo;
            if (a_act) begin
                mk     = cyc - a_t0 - 1;
                e_sclk = (mk < SHA) && ((mk % (2 * HA)) >= HA);
                e_upd  = (mk >= SHA) && (mk < SHA + HA);
                e_rdv  = (mk == SHA + HA);
                mbit   = mk / (2 * HA);
                if (mbit > WA - 1) mbit = WA - 1;
                e_sdo  = a_word[mbit];
            end
            check("sclk", 32'(a_sclk), 32'(e_sclk));
            check("sdo", 32'(a_sdo), 32'(e_sdo));
            check("upd", 32'(a_upd), 32'(e_upd));
            check("rd_valid", 32'(a_rd_valid), 32'(e_rdv));
            check("busy", 32'(a_busy), 32'(a_act && !e_rdv));
            if (a_rd_valid) begin
                if (a_exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL rd_unexpected: got rd_valid=1 required 0 (cycle %0d)", cyc);
                end else begin
                    check("rd_data", 32'(a_rd_data), 32'(a_exp_q.pop_front()));
                    check("shadow", 32'(a_shadow), 32'(a_word_q.pop_front()));
                    check("sclk_rises", 32'(a_rises - a_rise_q.pop_front()), 32'(WA));
                end
            end
            if (a_act && e_rdv) begin
                a_act = 1'b0;
                a_last_sdo = a_word[WA-1];
            end
            if (a_wr_valid) begin
                check("wr_ready", 32'(a_wr_ready), 32'(!a_act));
                if (!a_act) begin
                    a_act = 1'b1;
                    a_t0  = cyc;
                    a_word = a_wr_data;
                    a_exp_q.push_back(a_slave);
                    a_word_q.push_back(a_wr_data);
                    a_rise_q.push_back(a_rises);
                end
            end
        end
    end

    task automatic send(input logic [15:0] w);
        int n;
        a_wr_data = w;
        a_wr_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_wr_ready && n < 300);
        if (!a_wr_ready) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: got wr_ready=0 required 1 within 300 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        a_wr_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (a_busy && n < 300);
        if (a_busy) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: got busy=1 required 0 within 300 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          r0, n, bt0, brs, bi;
        logic [15:0] w;
        logic [7:0]  bw;

        rst = 1'b1;
        a_wr_valid = 1'b1;
        a_wr_data = 16'($urandom);
        b_wr_valid = 1'b0;
        b_wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        a_wr_valid = 1'b0;
        @(negedge clk);
        check("rst_wr_ready", 32'(a_wr_ready), 32'(1));
        check("rst_sclk", 32'(a_sclk), 32'(0));
        check("rst_sdo", 32'(a_sdo), 32'(0));
        check("rst_upd", 32'(a_upd), 32'(0));
        check("rst_rd_valid", 32'(a_rd_valid), 32'(0));
        check("rst_rd_data", 32'(a_rd_data), 32'(0));
        @(posedge clk);
        #1;

        send(16'hA5C3);
        wait_idle();
        check("single_shadow", 32'(a_shadow), 32'(16'hA5C3));

        send(16'hFFFF);
        send(16'h0001);
        wait_idle();
        check("b2b_shadow", 32'(a_shadow), 32'(16'h0001));

        send(16'h3C5A);
        a_wr_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        a_wr_valid = 1'b1;
        a_wr_data = 16'h5555;
        @(posedge clk);
        #1;
        wait_idle();
        check("ignore_shadow", 32'(a_shadow), 32'(16'h3C5A));

        // Abandon a transfer after the 7th sclk rise.
        r0 = a_rises;
        send(16'hC0DE);
        a_wr_valid = 1'b0;
        n = 0;
        while (a_rises - r0 < 7 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_rises_seen", 32'(a_rises - r0 >= 7), 32'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_sclk_low", 32'(a_sclk), 32'(0));
        repeat (80) @(negedge clk);
        check("abort_shadow", 32'(a_shadow), 32'(16'h3C5A));
        @(posedge clk);
        #1;
        w = 16'($urandom);
        send(w);
        wait_idle();
        check("post_abort_shadow", 32'(a_shadow), 32'(w));

        for (int i = 0; i < 6; i++) begin
            w = 16'($urandom);
            send(w);
            if ($urandom_range(0, 1) == 1) begin
                a_wr_valid = 1'b0;
                repeat ($urandom_range(1, 40)) @(posedge clk);
                #1;
                a_wr_valid = 1'b1;
                a_wr_data = 16'($urandom);
                @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 2) == 0) send(16'($urandom));
            wait_idle();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        // WIDTH=8, HALF=1 build: exact cycle positions relative to the handshake.
        bw = 8'h96;
        b_wr_data = bw;
        b_wr_valid = 1'b1;
        @(negedge clk);
        check("b_wr_ready", 32'(b_wr_ready), 32'(1));
        bt0 = cyc;
        brs = b_rises;
        @(posedge clk);
        #1 b_wr_valid = 1'b0;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            bi = (k / 2 > 7) ? 7 : k / 2;
            check("b_cycle", 32'(cyc - bt0 - 1), 32'(k));
            check("b_sclk", 32'(b_sclk), 32'((k < 16) && (k % 2 == 1)));
            check("b_sdo", 32'(b_sdo), 32'(bw[bi]));
            check("b_upd", 32'(b_upd), 32'(k == 16));
            check("b_rd_valid", 32'(b_rd_valid), 32'(k == 17));
        end
        check("b_rd_data", 32'(b_rd_data), 32'(8'h3C));
        check("b_shadow", 32'(b_shadow), 32'(8'h96));
        check("b_rises", 32'(b_rises - brs), 32'(8));

        check("a_drain", 32'(a_exp_q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
